kpad_scan_sequencer: RTL and testbench
======================================

// Module: kpad_scan_sequencer
// PURPOSE
//  Sequences a 4x4 matrix keypad: drives active-low row strobes, samples columns, debounces,
//  tracks press/hold/release and delivers one 4-bit key code per press over a valid/ready
//  handshake to the display/consumer path. Sits between the keypad pins and the sseg driver.
// PARAMETERS
//  SCAN_TICKS      100000  clk cycles per row slot (one "slot")
//  SETTLE          10      slot cycle index at which the synchronized col is sampled (< SCAN_TICKS)
//  DEBOUNCE_SCANS  4       consecutive matching samples required for press and for release (>=1)
//  REPEAT_DELAY    500     slots held before first auto-repeat (KPAD_TYPEMATIC_EN only)
//  REPEAT_RATE     100     slots between later auto-repeats (KPAD_TYPEMATIC_EN only)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  col        in   4  keypad columns, active-low, asynchronous to clk
//  row        out  4  row strobes, one-hot-low, registered
//  key_code   out  4  code = row_idx*4 + col_idx (row0/col0 -> 0x0, row3/col3 -> 0xF)
//  key_valid  out  1  key_code holds an undelivered event
//  key_ready  in   1  consumer accepts; transfer when key_valid && key_ready
//  key_held   out  1  a debounced key is currently pressed
//  overrun    out  1  one-cycle pulse: event dropped because key_valid was still pending
// BEHAVIOUR
//  Reset: row=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0, slot counter=0, FSM=SCAN.
//  col passes through a 2-flop synchronizer before any use; SETTLE must cover strobe+sync delay.
//  Slot counter 0..SCAN_TICKS-1 wraps; "sample" = cycle when counter==SETTLE (once per slot).
//  Row index r: row drives ~(1<<r). Valid col pattern = exactly one bit low; idx c = that bit.
//  FSM:
//   SCAN     r advances 0->1->2->3->0 at each slot wrap. At sample: valid pattern -> latch r,c,
//            count=1, go DEBOUNCE (row frozen on r). 4'b1111 or multi-low -> stay, keep scanning.
//   DEBOUNCE row frozen. Each sample: same pattern -> count+1; at count==DEBOUNCE_SCANS emit
//            event (code r*4+c), key_held=1, go HELD. Different pattern -> go SCAN, resume at r+1.
//            DEBOUNCE_SCANS==1: event emitted directly from SCAN's sample, FSM goes to HELD.
//   HELD     row frozen. Sample==4'b1111 -> go RELEASE, count=1; other pattern -> stay.
//   RELEASE  sample==4'b1111 -> count+1; at DEBOUNCE_SCANS: key_held=0, go SCAN resuming at r+1.
//            Any low col -> back to HELD (bounce, no new event).
//  Event latency: registered; key_valid rises the cycle after the qualifying sample.
//  Output register (1 entry): event with key_valid=0, or key_valid&&key_ready same cycle ->
//   load key_code, key_valid=1. Event while key_valid && !key_ready -> old code kept, overrun
//   pulses 1 cycle. key_valid falls the cycle after a transfer with no simultaneous event.
//  key_code stable while key_valid=1; key_ready ignored while key_valid=0.
//  Second key pressed while HELD: ignored until release completes (no rollover).
//  rst_n asserted mid-operation: immediate return to reset values, pending event discarded.
// CONFIGURATION
//  KPAD_TYPEMATIC_EN defined: in HELD, slot counter of hold time; first repeat event at
//   REPEAT_DELAY slots after entering HELD, then every REPEAT_RATE slots; same code, same
//   handshake/overrun rules; counter clears on leaving HELD; RELEASE excursion does not reset it.
//  Undefined: exactly one event per debounced press; no hold counter logic synthesized.
// TESTING (SCAN_TICKS=8, SETTLE=3, DEBOUNCE_SCANS=2, REPEAT_DELAY=4, REPEAT_RATE=2)
//  1 Reset, idle col=4'hF -> row cycles 1110,1101,1011,0111 every 8 clk; key_valid=0 throughout.
//  2 Hold col=4'b1011 while row2 strobed, key_ready=1 -> exactly one key_valid pulse, key_code=0xA,
//    key_held=1; release -> key_held=0 after 2 clean samples, scanning resumes at row3.
//  3 Bounce: col low for 1 sample then 4'hF -> no event; FSM back to SCAN.
//  4 key_ready=0, press 0x5, release, press 0x9 -> key_valid=1 code 0x5 kept, overrun pulses once;
//    then key_ready=1 -> transfer 0x5, key_valid drops next cycle.
//  5 Press col=4'b1100 (two keys) on row0 -> ignored, no event; assert rst_n=0 mid-DEBOUNCE ->
//    all outputs at reset values, row=1110.
//  6 KPAD_TYPEMATIC_EN, hold 0x3 for 10 slots, key_ready=1 -> events at press, +4, +6, +8, +10.

Source files
------------

// File: rtl/kpad_scan_sequencer.sv
// -----------------------------------------------------------------------------
// kpad_scan_sequencer
//
// Purpose:
//   Scans a 4x4 matrix keypad. It drives one active-low row strobe at a time,
//   samples the (synchronized) active-low columns once per row slot, debounces
//   press and release, and hands one 4-bit key code per debounced press to the
//   consumer through a single-entry valid/ready output register. An event that
//   arrives while that register is still full is dropped and flagged with a
//   one-cycle overrun pulse.
//
// Optional feature (compile-time macro):
//   KPAD_TYPEMATIC_EN - while a key stays held, repeat its code after
//                       REPEAT_DELAY slots and then every REPEAT_RATE slots.
//                       Without the macro no hold-time counter exists.
//
// Ports:
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   col        in   4  keypad columns, active-low, asynchronous to clk
//   row        out  4  row strobes, one-hot-low, registered
//   key_code   out  4  row_idx*4 + col_idx of the pending event
//   key_valid  out  1  key_code holds an undelivered event
//   key_ready  in   1  consumer accepts (transfer on key_valid && key_ready)
//   key_held   out  1  a debounced key is currently pressed
//   overrun    out  1  one-cycle pulse: event dropped, output register full
// -----------------------------------------------------------------------------
module kpad_scan_sequencer #(
    parameter int SCAN_TICKS     = 100000,
    parameter int SETTLE         = 10,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int SLOT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(SCAN_TICKS - 1);
    localparam logic [SLOT_W-1:0] SLOT_SAMPLE = SLOT_W'(SETTLE);
    localparam logic [SLOT_W-1:0] SLOT_ONE    = SLOT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DONE    = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic              SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Returns {valid, index}: valid only when exactly one column is pulled low.
    function automatic logic [2:0] decode_col(input logic [3:0] pat);
        logic [2:0] res;
        case (pat)
            4'b1110: res = {1'b1, 2'd0};
            4'b1101: res = {1'b1, 2'd1};
            4'b1011: res = {1'b1, 2'd2};
            4'b0111: res = {1'b1, 2'd3};
            default: res = {1'b0, 2'd0};
        endcase
        return res;
    endfunction

    // One-hot-low strobe pattern for a row index.
    function automatic logic [3:0] row_strobe(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    logic [3:0]        r_col_meta;
    logic [3:0]        r_col_sync;
    logic [SLOT_W-1:0] r_slot_cnt;
    state_t            r_state;
    logic [1:0]        r_row_idx;
    logic [3:0]        r_row;
    logic [3:0]        r_col_pat;
    logic [1:0]        r_col_idx;
    logic [CNT_W-1:0]  r_count;
    logic              r_key_held;
    logic [3:0]        r_key_code;
    logic              r_key_valid;
    logic              r_overrun;

    logic              w_sample;
    logic              w_slot_wrap;
    logic [2:0]        w_dec;
    logic              w_pat_valid;
    logic              w_pat_idle;
    logic              w_press_evt;
    logic              w_rep_evt;
    logic              w_evt;
    logic [3:0]        w_evt_code;

    assign w_sample    = (r_slot_cnt == SLOT_SAMPLE);
    assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
    assign w_dec       = decode_col(r_col_sync);
    assign w_pat_valid = w_dec[2];
    assign w_pat_idle  = (r_col_sync == 4'b1111);

    // Two-flop synchronizer for the asynchronous column inputs (idle = all high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_meta <= 4'b1111;
            r_col_sync <= 4'b1111;
        end else begin
            r_col_meta <= col;
            r_col_sync <= r_col_meta;
        end
    end

    // Free-running row slot counter; the sample point is a fixed offset in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
        end else if (w_slot_wrap) begin
            r_slot_cnt <= '0;
        end else begin
            r_slot_cnt <= r_slot_cnt + SLOT_ONE;
        end
    end

    // Debounced-press qualification at the sample point.
    always_comb begin
        w_press_evt = 1'b0;
        if (w_sample) begin
            case (r_state)
                ST_SCAN:     w_press_evt = w_pat_valid && SINGLE_SCAN;
                ST_DEBOUNCE: w_press_evt = (r_col_sync == r_col_pat) &&
                                           ((r_count + CNT_ONE) == CNT_DONE);
                default:     w_press_evt = 1'b0;
            endcase
        end else begin
            w_press_evt = 1'b0;
        end
    end

`ifdef KPAD_TYPEMATIC_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_C = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE_C  = REP_W'(REPEAT_RATE);
    localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);

    // Samples remaining until the next repeat; stays on schedule through a
    // release bounce, so a repeat due during RELEASE is skipped, not delayed.
    logic [REP_W-1:0] r_rep_cnt;
    logic             w_in_hold;
    logic             w_rep_due;

    assign w_in_hold = (r_state == ST_HELD) || (r_state == ST_RELEASE);
    assign w_rep_due = w_sample && w_in_hold && (r_rep_cnt == REP_ONE);

    // Repeat fires only from a steady HELD sample that is still pressed.
    always_comb begin
        w_rep_evt = 1'b0;
        if (w_rep_due && (r_state == ST_HELD) && !w_pat_idle) begin
            w_rep_evt = 1'b1;
        end else begin
            w_rep_evt = 1'b0;
        end
    end

    // Hold-time countdown, armed by the debounced press, cleared back in SCAN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
        end else if (w_press_evt) begin
            r_rep_cnt <= REP_DELAY_C;
        end else if (w_sample && w_in_hold) begin
            if (r_rep_cnt == REP_ONE) begin
                r_rep_cnt <= REP_RATE_C;
            end else if (r_rep_cnt != '0) begin
                r_rep_cnt <= r_rep_cnt - REP_ONE;
            end
        end else if (r_state == ST_SCAN) begin
            r_rep_cnt <= '0;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
    assign w_rep_evt    = 1'b0;
`endif

    assign w_evt      = w_press_evt || w_rep_evt;
    // Press codes come straight from the sample (equal to the latched pattern
    // in DEBOUNCE); repeats reuse the latched column.
    assign w_evt_code = w_press_evt ? {r_row_idx, w_dec[1:0]} : {r_row_idx, r_col_idx};

    // Scan / debounce / hold / release sequencer with registered row and held flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SCAN;
            r_row_idx  <= 2'd0;
            r_row      <= 4'b1110;
            r_col_pat  <= 4'b1111;
            r_col_idx  <= 2'd0;
            r_count    <= '0;
            r_key_held <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_sample && w_pat_valid) begin
                        // Freeze on this row while the press is qualified.
                        r_col_pat <= r_col_sync;
                        r_col_idx <= w_dec[1:0];
                        r_count   <= CNT_ONE;
                        if (w_press_evt) begin
                            r_state    <= ST_HELD;
                            r_key_held <= 1'b1;
                        end else begin
                            r_state <= ST_DEBOUNCE;
                        end
                    end else if (w_slot_wrap) begin
                        r_row_idx <= r_row_idx + 2'd1;
                        r_row     <= row_strobe(r_row_idx + 2'd1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_sample) begin
                        if (r_col_sync == r_col_pat) begin
                            if (w_press_evt) begin
                                r_state    <= ST_HELD;
                                r_key_held <= 1'b1;
                            end else begin
                                r_count <= r_count + CNT_ONE;
                            end
                        end else begin
                            // Bounce: abandon, the next slot wrap moves on to r+1.
                            r_state <= ST_SCAN;
                            r_count <= '0;
                            if (w_slot_wrap) begin
                                r_row_idx <= r_row_idx + 2'd1;
                                r_row     <= row_strobe(r_row_idx + 2'd1);
                            end
                        end
                    end
                end
                ST_HELD: begin
                    if (w_sample && w_pat_idle) begin
                        if (SINGLE_SCAN) begin
                            r_state    <= ST_SCAN;
                            r_key_held <= 1'b0;
                            r_count    <= '0;
                            if (w_slot_wrap) begin
                                r_row_idx <= r_row_idx + 2'd1;
                                r_row     <= row_strobe(r_row_idx + 2'd1);
                            end
                        end else begin
                            r_state <= ST_RELEASE;
                            r_count <= CNT_ONE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (w_sample) begin
                        if (w_pat_idle) begin
                            if ((r_count + CNT_ONE) == CNT_DONE) begin
                                r_state    <= ST_SCAN;
                                r_key_held <= 1'b0;
                                r_count    <= '0;
                                if (w_slot_wrap) begin
                                    r_row_idx <= r_row_idx + 2'd1;
                                    r_row     <= row_strobe(r_row_idx + 2'd1);
                                end
                            end else begin
                                r_count <= r_count + CNT_ONE;
                            end
                        end else begin
                            // Release bounce: still the same press, no new event.
                            r_state <= ST_HELD;
                            r_count <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Single-entry output register with valid/ready handshake and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_evt) begin
            if (!r_key_valid || key_ready) begin
                r_key_code  <= w_evt_code;
                r_key_valid <= 1'b1;
                r_overrun   <= 1'b0;
            end else begin
                r_overrun   <= 1'b1;
            end
        end else begin
            r_overrun <= 1'b0;
            if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign row       = r_row;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_kpad_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_kpad_scan_sequencer
//
// Self-checking bench. A keypad model turns a 16-bit "pressed keys" mask and
// the DUT row strobes into column levels. A slot-level reference model tracks
// which row is scanned, the debounced key state and the one-entry output
// register, and every DUT output is compared on each falling clock edge.
// Key presses change only at slot starts.
// -----------------------------------------------------------------------------
module tb_kpad_scan_sequencer;

    localparam int ST  = 8;
    localparam int SET = 3;
    localparam int DS  = 2;
    localparam int RD  = 4;
    localparam int RR  = 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        key_ready = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        overrun;
    logic [15:0] pressed   = 16'h0000;

    int errors   = 0;
    int checks   = 0;
    int rdy_mode = 0;   // 0: ready=1, 1: ready=0, 2: random each cycle

    // Reference model state
    int         m_ph;
    int         m_row;
    int         m_streak;
    int         m_rel;
    int         m_hold;
    bit         m_down;
    logic [3:0] m_cand;
    logic [3:0] m_key;
    bit         m_valid;
    bit         m_ovr;
    logic [3:0] m_code;

    kpad_scan_sequencer #(
        .SCAN_TICKS(ST), .SETTLE(SET), .DEBOUNCE_SCANS(DS),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .col(col), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is strobed.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (row[r] == 1'b0) col = col & ~pressed[r*4 +: 4];
        end
    end

    function automatic logic [3:0] pattern(input logic [15:0] pr, input int r);
        return ~pr[r*4 +: 4];
    endfunction

    // Column index when exactly one column is low, else -1.
    function automatic int onehot_idx(input logic [3:0] p);
        int idx;
        idx = -1;
        if ($countones(~p) == 1) begin
            for (int c = 0; c < 4; c++) if (p[c] == 1'b0) idx = c;
        end
        return idx;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_row = 0; m_streak = 0; m_rel = 0; m_hold = 0;
        m_down = 1'b0; m_cand = 4'hF; m_key = 4'h0;
        m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'h0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        bit         evt;
        bit         was_steady;
        logic [3:0] ecode;
        logic [3:0] p;
        evt = 1'b0; ecode = 4'h0;
        if (m_ph == SET) begin
            p = pattern(pressed, m_row);
            if (!m_down) begin
                if (m_streak == 0) begin
                    if (onehot_idx(p) >= 0) begin m_cand = p; m_streak = 1; end
                end else if (p == m_cand) begin
                    m_streak++;
                end else begin
                    m_streak = 0;
                end
                if (m_streak == DS) begin
                    m_down = 1'b1; m_rel = 0; m_hold = 0; evt = 1'b1;
                    m_key = 4'(m_row * 4 + onehot_idx(m_cand));
                    ecode = m_key;
                end
            end else begin
                was_steady = (m_rel == 0);
                m_hold++;
                if (p == 4'hF) begin
                    m_rel++;
                    if (m_rel == DS) begin m_down = 1'b0; m_streak = 0; m_rel = 0; end
                end else begin
                    m_rel = 0;
                end
`ifdef KPAD_TYPEMATIC_EN
                if (was_steady && p != 4'hF &&
                    (m_hold == RD || (m_hold > RD && ((m_hold - RD) % RR) == 0))) begin
                    evt = 1'b1; ecode = m_key;
                end
`else
                if (was_steady) evt = 1'b0;
`endif
            end
        end
        if (m_ph == ST - 1 && !m_down && m_streak == 0) m_row = (m_row + 1) % 4;
        if (evt) begin
            if (!m_valid || key_ready) begin m_code = ecode; m_valid = 1'b1; m_ovr = 1'b0; end
            else m_ovr = 1'b1;
        end else begin
            m_ovr = 1'b0;
            if (m_valid && key_ready) m_valid = 1'b0;
        end
        m_ph = (m_ph + 1) % ST;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] exp_row;
        exp_row = ~(4'b0001 << m_row);
        chk({tag, "_row"},   row, exp_row);
        chk({tag, "_valid"}, {3'b000, key_valid}, {3'b000, m_valid});
        chk({tag, "_code"},  key_code, m_code);
        chk({tag, "_held"},  {3'b000, key_held}, {3'b000, m_down});
        chk({tag, "_ovr"},   {3'b000, overrun},  {3'b000, m_ovr});
    endtask

    task automatic cyc(input string tag);
        if (rdy_mode == 2) key_ready = 1'($urandom_range(0, 1));
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic run_slots(input string tag, input int n);
        repeat (n * ST) cyc(tag);
    endtask

    task automatic align_slot(input string tag);
        while (m_ph != 0) cyc(tag);
    endtask

    // Wait (bounded) for the start of the slot that strobes row r.
    task automatic align_row(input string tag, input int r);
        int n;
        n = 0;
        while (!(m_ph == 0 && m_row == r) && n < 64) begin cyc(tag); n++; end
        checks++;
        assert (m_ph == 0 && m_row == r) else begin
            errors++;
            $error("FAIL %s_align observed=row%0d expected=row%0d", tag, m_row, r);
        end
    endtask

    task automatic set_ready(input int mode);
        rdy_mode = mode;
        if (mode == 0) key_ready = 1'b1;
        else if (mode == 1) key_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] mask;
        model_reset();
        #1 rst_n = 1'b0;
        #20;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scanning: rows rotate, nothing valid
        set_ready(0);
        run_slots("idle", 5);

        // Single press of 0xA (row2/col2), then release and resume at row3
        align_slot("t2");
        pressed = 16'h0400;
        run_slots("t2_press", 10);
        pressed = 16'h0000;
        run_slots("t2_rel", 6);

        // One-sample bounce on row1: no event
        align_row("t3", 1);
        pressed = 16'h0040;
        run_slots("t3_bounce", 1);
        pressed = 16'h0000;
        run_slots("t3_after", 5);

        // Consumer stalled: second press overruns, then drain
        set_ready(1);
        align_slot("t4");
        pressed = 16'h0020;
        run_slots("t4_p5", 8);
        pressed = 16'h0000;
        run_slots("t4_r5", 6);
        pressed = 16'h0200;
        run_slots("t4_p9", 8);
        pressed = 16'h0000;
        run_slots("t4_r9", 5);
        set_ready(0);
        run_slots("t4_drain", 1);

        // Two keys on row0 are ignored
        align_slot("t5");
        pressed = 16'h0003;
        run_slots("t5_multi", 8);
        pressed = 16'h0000;
        run_slots("t5_idle", 2);

        // Reset while debouncing a press of 0x4
        align_row("t5d", 1);
        pressed = 16'h0010;
        repeat (SET + 2) cyc("t5_deb");
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all("t5_rst");
        pressed = 16'h0000;
        @(negedge clk);
        check_all("t5_rst_hold");
        rst_n = 1'b1;
        run_slots("t5_post", 4);

`ifdef KPAD_TYPEMATIC_EN
        // Long hold of 0x3 with auto-repeat
        set_ready(0);
        align_slot("t6");
        pressed = 16'h0008;
        run_slots("t6_hold", 16);
        pressed = 16'h0000;
        run_slots("t6_rel", 6);
`endif

        // Randomized presses, hold lengths and consumer behaviour
        for (int e = 0; e < 24; e++) begin
            mask = 16'h0001 << $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) mask = mask | (16'h0001 << $urandom_range(0, 15));
            set_ready($urandom_range(0, 2));
            align_slot("rnd");
            pressed = mask;
            run_slots("rnd_press", $urandom_range(1, 14));
            pressed = 16'h0000;
            run_slots("rnd_rel", $urandom_range(1, 8));
        end
        set_ready(0);
        run_slots("final", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
